// File: rtl/fir_serial_multichan.sv
// Multi-channel serial FIR: LSB-first frame in, per-channel delay line, shared
// runtime-loadable coefficient bank, one time-multiplexed MAC, LSB-first frame out.
module fir_serial_multichan #(
  parameter  int DATA_WIDTH = 24,
  parameter  int COEF_WIDTH = 18,
  parameter  int FIR_DEPTH  = 32,
  parameter  int NUM_CH     = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW         = $clog2(FIR_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_din,
  input  logic                  i_din_valid,
  input  logic [CH_W-1:0]       i_ch,
  input  logic                  i_bypass,
  input  logic                  i_clear,
  input  logic                  i_coef_we,
  input  logic [AW-1:0]         i_coef_addr,
  input  logic [COEF_WIDTH-1:0] i_coef_data,
  input  logic                  i_ready,
  output logic                  o_ready,
  output logic                  o_dout,
  output logic                  o_dout_valid,
  output logic [CH_W-1:0]       o_dout_ch,
  output logic                  o_coef_err
);

  localparam int HW    = CH_W + AW;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int PW    = DATA_WIDTH + COEF_WIDTH;
  localparam int ACCW  = PW + AW;
  localparam int DEPTH = NUM_CH * FIR_DEPTH;
  localparam logic [HW-1:0] CLR_LAST = HW'(DEPTH - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX =
    {{(ACCW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN =
    {{(ACCW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_RX, S_WRITE, S_MAC, S_HOLD, S_TX
  } state_t;

  state_t                        state;
  logic [HW-1:0]                 clr_cnt;
  logic [CNT_W-1:0]              bit_cnt;
  logic [AW-1:0]                 tap_k;
  logic [CH_W-1:0]               ch_q;
  logic                          byp_q;
  logic [DATA_WIDTH-1:0]         rx_sr;
  logic [DATA_WIDTH-1:0]         tx_sr;
  logic signed [ACCW-1:0]        acc;
  logic [AW-1:0]                 wptr [NUM_CH];
  logic signed [COEF_WIDTH-1:0]  coef [FIR_DEPTH];
  logic signed [DATA_WIDTH-1:0]  hist [DEPTH];

  logic                          hist_we;
  logic [HW-1:0]                 hist_wa;
  logic [DATA_WIDTH-1:0]         hist_wd;
  logic [HW-1:0]                 rd_addr;
  logic signed [DATA_WIDTH-1:0]  hist_rd;
  logic signed [PW-1:0]          prod;
  logic signed [ACCW-1:0]        shifted;
  logic [DATA_WIDTH-1:0]         sat_val;
  logic [DATA_WIDTH-1:0]         result;
  logic                          coef_reject;

  // Tap 0 is the newest sample, which sits just behind the post-increment pointer.
  assign rd_addr = {ch_q, AW'(wptr[ch_q] - AW'(1) - tap_k)};
  assign hist_rd = hist[rd_addr];
  assign prod    = PW'(coef[tap_k]) * PW'(hist_rd);
  assign shifted = acc >>> (COEF_WIDTH - 1);

  always_comb begin
    sat_val = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX)
      sat_val = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN)
      sat_val = SAT_MIN[DATA_WIDTH-1:0];
  end

  assign result = byp_q ? rx_sr : sat_val;

  // The edge that leaves WRITE for MAC already counts as a MAC-time write.
  assign coef_reject = i_coef_we &&
                       ((state == S_MAC) || ((state == S_WRITE) && !byp_q));

  assign hist_we = i_rst && i_en && ((state == S_CLEAR) || (state == S_WRITE));
  assign hist_wa = (state == S_CLEAR) ? clr_cnt : {ch_q, wptr[ch_q]};
  assign hist_wd = (state == S_CLEAR) ? '0 : rx_sr;

  always_ff @(posedge i_clk) begin
    if (hist_we) hist[hist_wa] <= hist_wd;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= S_CLEAR;
      clr_cnt      <= '0;
      bit_cnt      <= '0;
      tap_k        <= '0;
      ch_q         <= '0;
      byp_q        <= 1'b0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      acc          <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) wptr[i] <= '0;
      for (int unsigned i = 0; i < FIR_DEPTH; i++) coef[i] <= '0;
      o_ready      <= 1'b0;
      o_dout       <= 1'b0;
      o_dout_valid <= 1'b0;
      o_dout_ch    <= '0;
      o_coef_err   <= 1'b0;
    end else if (i_en) begin
      o_coef_err <= coef_reject;
      if (i_coef_we && !coef_reject) coef[i_coef_addr] <= i_coef_data;

      unique case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + HW'(1);
          if (clr_cnt == CLR_LAST) begin
            state   <= S_IDLE;
            o_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (i_clear) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            o_ready <= 1'b0;
          end else if (i_din_valid) begin
            state   <= S_RX;
            ch_q    <= i_ch;
            byp_q   <= i_bypass;
            bit_cnt <= '0;
            o_ready <= 1'b0;
          end
        end
        S_RX: begin
          rx_sr <= {i_din, rx_sr[DATA_WIDTH-1:1]};
          if (bit_cnt == CNT_W'(DATA_WIDTH - 1))
            state <= S_WRITE;
          else
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
        S_WRITE: begin
          wptr[ch_q] <= wptr[ch_q] + AW'(1);
          acc        <= '0;
          tap_k      <= '0;
          state      <= byp_q ? S_HOLD : S_MAC;
        end
        S_MAC: begin
          acc   <= acc + ACCW'(prod);
          tap_k <= tap_k + AW'(1);
          if (tap_k == AW'(FIR_DEPTH - 1)) state <= S_HOLD;
        end
        S_HOLD: begin
          if (!o_dout_valid) begin
            o_dout_valid <= 1'b1;
            o_dout_ch    <= ch_q;
            tx_sr        <= result;
          end else if (i_ready) begin
            o_dout_valid <= 1'b0;
            o_dout       <= tx_sr[0];
            tx_sr        <= tx_sr >> 1;
            bit_cnt      <= CNT_W'(1);
            state        <= S_TX;
          end
        end
        S_TX: begin
          if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
            o_dout  <= 1'b0;
            o_ready <= 1'b1;
            state   <= S_IDLE;
          end else begin
            o_dout  <= tx_sr[0];
            tx_sr   <= tx_sr >> 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_multichan.sv
// Directed bench for fir_serial_multichan: hand-computed frames through the
// filter, bypass, pointer wrap, saturation, coefficient guard, reset and clear.
module tb_fir_serial_multichan;

  localparam int DW = 24;
  localparam int CW = 18;
  localparam int FD = 32;
  localparam int NC = 2;

  logic          tb_clk;
  logic          i_rst;
  logic          i_en;
  logic          i_din;
  logic          i_din_valid;
  logic [0:0]    i_ch;
  logic          i_bypass;
  logic          i_clear;
  logic          i_coef_we;
  logic [4:0]    i_coef_addr;
  logic [CW-1:0] i_coef_data;
  logic          i_ready;
  logic          o_ready;
  logic          o_dout;
  logic          o_dout_valid;
  logic [0:0]    o_dout_ch;
  logic          o_coef_err;

  int checks = 0;
  int errs   = 0;

  fir_serial_multichan #(
    .DATA_WIDTH(DW),
    .COEF_WIDTH(CW),
    .FIR_DEPTH (FD),
    .NUM_CH    (NC)
  ) dut (
    .i_clk       (tb_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_din       (i_din),
    .i_din_valid (i_din_valid),
    .i_ch        (i_ch),
    .i_bypass    (i_bypass),
    .i_clear     (i_clear),
    .i_coef_we   (i_coef_we),
    .i_coef_addr (i_coef_addr),
    .i_coef_data (i_coef_data),
    .i_ready     (i_ready),
    .o_ready     (o_ready),
    .o_dout      (o_dout),
    .o_dout_valid(o_dout_valid),
    .o_dout_ch   (o_dout_ch),
    .o_coef_err  (o_coef_err)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input logic [CW-1:0] data);
    i_coef_we   = 1'b1;
    i_coef_addr = 5'(addr);
    i_coef_data = data;
    step();
    i_coef_we   = 1'b0;
  endtask

  task automatic zero_coefs();
    for (int a = 0; a < FD; a++) write_coef(a, '0);
  endtask

  // Expects to be called just after the edge that starts a clear sequence.
  task automatic clear_wait(input string tag);
    bit low_ok = 1'b1;
    bit quiet_ok = 1'b1;
    for (int c = 1; c <= NC * FD; c++) begin
      step();
      if (c < NC * FD && o_ready) low_ok = 1'b0;
      if (o_dout_valid || o_dout) quiet_ok = 1'b0;
    end
    check({tag, "_ready_low"}, 64'(low_ok), 1);
    check({tag, "_quiet"}, 64'(quiet_ok), 1);
    check({tag, "_ready_high"}, 64'(o_ready), 1);
  endtask

  task automatic send_frame(input int ch, input bit byp, input logic [DW-1:0] data);
    int n = 0;
    while (!o_ready && n < 500) begin
      step();
      n++;
    end
    check("ready_wait", 64'(o_ready), 1);
    i_din_valid = 1'b1;
    i_ch        = 1'(ch);
    i_bypass    = byp;
    step();
    i_din_valid = 1'b0;
    i_bypass    = 1'b0;
    for (int j = 0; j < DW; j++) begin
      i_din = data[j];
      step();
    end
    i_din = 1'b0;
  endtask

  // lat != 0 means recv directly follows send_frame and the valid latency is checked.
  task automatic recv_frame(input string tag, input int ch, input logic [DW-1:0] exp,
                            input int lat, input int hold, input bit chk);
    int cnt = DW;
    logic [DW-1:0] got = '0;
    while (!o_dout_valid && cnt < 300) begin
      step();
      cnt++;
    end
    check({tag, "_valid"}, 64'(o_dout_valid), 1);
    if (lat != 0) check({tag, "_latency"}, 64'(cnt), 64'(lat));
    check({tag, "_ch"}, 64'(o_dout_ch), 64'(ch));
    if (hold != 0) begin
      repeat (hold) step();
      check({tag, "_held"}, 64'(o_dout_valid), 1);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    for (int j = 0; j < DW; j++) begin
      got[j] = o_dout;
      step();
    end
    if (chk) check({tag, "_data"}, 64'(got), 64'(exp));
    check({tag, "_end"}, {62'd0, o_ready, o_dout}, 64'd2);
  endtask

  task automatic run_frame(input string tag, input int ch, input bit byp,
                           input logic [DW-1:0] data, input logic [DW-1:0] exp,
                           input int lat);
    send_frame(ch, byp, data);
    recv_frame(tag, ch, exp, lat, 0, 1'b1);
  endtask

  function automatic logic [DW-1:0] wrap_exp(input int n);
    if (n <= 28) return 24'd0;
    if (n == 29) return 24'd999;
    if (n == 30) return 24'd1999;
    if (n == 31) return 24'd0;
    return 24'd7;
  endfunction

  initial begin
    i_rst = 1'b0; i_en = 1'b1; i_din = 1'b0; i_din_valid = 1'b0; i_ch = '0;
    i_bypass = 1'b0; i_clear = 1'b0; i_coef_we = 1'b0; i_coef_addr = '0;
    i_coef_data = '0; i_ready = 1'b0;

    // 1: reset state and power-on clear
    repeat (3) step();
    check("rst_ready", 64'(o_ready), 0);
    check("rst_valid", 64'(o_dout_valid), 0);
    check("rst_dout", 64'(o_dout), 0);
    check("rst_coef_err", 64'(o_coef_err), 0);
    i_rst = 1'b1;
    clear_wait("por");

    // 2: two half-weight taps on ch0
    write_coef(0, 18'd65536);
    write_coef(1, 18'd65536);
    check("idle_write_no_err", 64'(o_coef_err), 0);
    send_frame(0, 1'b0, 24'd1000);
    recv_frame("t2a", 0, 24'd500, 58, 4, 1'b1);
    run_frame("t2b", 0, 1'b0, 24'd2000, 24'd1500, 58);

    // 3: channel isolation, then pointer wrap through tap 31
    run_frame("t3_ch1", 1, 1'b0, 24'd4000, 24'd2000, 58);
    run_frame("t3_ch0", 0, 1'b0, 24'd0, 24'd1000, 58);
    zero_coefs();
    write_coef(31, 18'd131071);
    for (int n = 1; n <= 33; n++) begin
      send_frame(0, 1'b0, 24'd8);
      recv_frame($sformatf("t3_wrap%0d", n), 0, wrap_exp(n), 0, 0, (n >= 29));
    end

    // 4: saturation with all taps near unity
    for (int a = 0; a < FD; a++) write_coef(a, 18'd131071);
    run_frame("t4_pos1", 0, 1'b0, 24'h7FFFFF, 24'h7FFFFF, 0);
    run_frame("t4_pos2", 0, 1'b0, 24'h7FFFFF, 24'h7FFFFF, 0);
    run_frame("t4_neg1", 0, 1'b0, 24'h800000, 24'h7FFFFF, 0);
    run_frame("t4_neg2", 0, 1'b0, 24'h800000, 24'd221, 0);
    run_frame("t4_neg3", 0, 1'b0, 24'h800000, 24'h800115, 0);
    run_frame("t4_neg4", 0, 1'b0, 24'h800000, 24'h800000, 0);

    // 5: bypass still feeds the delay line
    zero_coefs();
    write_coef(1, 18'd65536);
    run_frame("t5_byp", 1, 1'b1, 24'hABCDEF, 24'hABCDEF, 26);
    run_frame("t5_tap1", 1, 1'b0, 24'd0, 24'hD5E6F7, 58);

    // 6a: write attempt during MAC is rejected
    send_frame(1, 1'b0, 24'd50);
    repeat (5) step();
    i_coef_we = 1'b1; i_coef_addr = 5'd0; i_coef_data = 18'd65536;
    step();
    i_coef_we = 1'b0;
    check("t6_err_pulse", 64'(o_coef_err), 1);
    step();
    check("t6_err_clear", 64'(o_coef_err), 0);
    recv_frame("t6_mac", 1, 24'd0, 0, 0, 1'b1);
    run_frame("t6_after", 1, 1'b0, 24'd60, 24'd25, 58);

    // 6b: reset in the middle of a transmit
    send_frame(1, 1'b1, 24'hFFFFFF);
    begin
      int n = 0;
      while (!o_dout_valid && n < 100) begin
        step();
        n++;
      end
    end
    check("t6_rst_valid", 64'(o_dout_valid), 1);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    repeat (3) step();
    check("t6_tx_bit", 64'(o_dout), 1);
    i_rst = 1'b0;
    #1;
    check("t6_rst_dout", 64'(o_dout), 0);
    check("t6_rst_dvalid", 64'(o_dout_valid), 0);
    check("t6_rst_ready", 64'(o_ready), 0);
    step();
    i_rst = 1'b1;
    clear_wait("rst2");

    // 6c: history clear from IDLE
    write_coef(1, 18'd65536);
    run_frame("t6_pre", 0, 1'b0, 24'd300, 24'd0, 58);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    clear_wait("clr");
    run_frame("t6_post_clr", 0, 1'b0, 24'd100, 24'd0, 58);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
